// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-side memory responder: MMIO offsets,
// the LED board geometry and the address-decode result type.
package data_mem_pkg;

    localparam int NROWS = 8;

    localparam logic [31:0] ROW0_OFF   = 32'h0000_0000;
    localparam logic [31:0] CYCLE_OFF  = 32'h0000_0020;
    localparam logic [31:0] STATUS_OFF = 32'h0000_0024;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_ROW,
        SEL_CYCLE,
        SEL_STATUS,
        SEL_NONE
    } sel_t;

    // Word-truncated decode; an address below io_base wraps the offset high
    // and therefore falls through to SEL_NONE.
    function automatic sel_t decode(input logic [31:0] addr,
                                    input logic [31:0] ram_bytes,
                                    input logic [31:0] io_base);
        logic [31:0] word_addr;
        logic [31:0] off;
        word_addr = {addr[31:2], 2'b00};
        off       = word_addr - {io_base[31:2], 2'b00};
        if (word_addr < ram_bytes)
            return SEL_RAM;
        else if ((off - ROW0_OFF) < 32'(4 * NROWS))
            return SEL_ROW;
        else if (off == CYCLE_OFF)
            return SEL_CYCLE;
        else if (off == STATUS_OFF)
            return SEL_STATUS;
        else
            return SEL_NONE;
    endfunction

endpackage

// File: rtl/data_mem_mmio_if.sv
// Data port of the single-cycle core: store strobe, byte address, store data
// and combinational load data.
interface data_mem_mmio_if;

    logic        mem_write;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [31:0] read_data;

    modport master (
        output mem_write,
        output alu_result,
        output write_data,
        input  read_data
    );

    modport slave (
        input  mem_write,
        input  alu_result,
        input  write_data,
        output read_data
    );

endinterface

// File: rtl/data_mem_mmio_led_scanner.sv
// Row-scanning driver for the 8x8 LED board: prescaler, row index and
// registered one-hot row enable plus column data.
module led_scanner
    import data_mem_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NROWS-1:0][7:0] rows,
    output logic                  frame_wrap,
    output logic [7:0]            row_sel,
    output logic [7:0]            col
);

    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0] presc_reg;
    logic [2:0]    row_idx_reg;
    logic [2:0]    row_idx_next;
    logic          row_step;
    logic [7:0]    row_sel_reg;
    logic [7:0]    col_reg;

    assign row_step     = (presc_reg == PW'(SCAN_DIV - 1));
    assign row_idx_next = row_step ? row_idx_reg + 3'd1 : row_idx_reg;
    assign frame_wrap   = row_step && (row_idx_reg == 3'(NROWS - 1));

    // Outputs track the row that will be active after this edge, so
    // row_sel and the row index always change together.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_reg   <= '0;
            row_idx_reg <= '0;
            row_sel_reg <= 8'h01;
            col_reg     <= 8'h00;
        end else begin
            presc_reg   <= row_step ? '0 : presc_reg + 1'b1;
            row_idx_reg <= row_idx_next;
            row_sel_reg <= 8'h01 << row_idx_next;
            col_reg     <= rows[row_idx_next];
        end
    end

    assign row_sel = row_sel_reg;
    assign col     = col_reg;

endmodule

// File: rtl/data_mem_mmio.sv
// Data memory responder for the single-cycle core: word RAM with
// combinational reads plus an MMIO bank (LED board rows, cycle counter, status).
module data_mem_mmio
    import data_mem_pkg::*;
#(
    parameter int          DEPTH    = 256,
    parameter logic [31:0] IO_BASE  = 32'h0000_1000,
    parameter int          SCAN_DIV = 1000
) (
    input  logic           clk,
    input  logic           reset,
    data_mem_mmio_if.slave bus,
    output logic [7:0]     row_sel,
    output logic [7:0]     col
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);

    logic [31:0]           ram [DEPTH];
    logic [NROWS-1:0][7:0] row_reg;
    logic [NROWS-1:0]      row_we;
    logic [31:0]           cycle_reg;
    logic                  frame_done_reg;

    sel_t                  sel;
    logic [AW-1:0]         ram_idx;
    logic [2:0]            row_idx;
    logic                  status_clr;
    logic                  frame_wrap;

    assign sel     = decode(bus.alu_result, RAM_BYTES, IO_BASE);
    assign ram_idx = bus.alu_result[AW+1:2];
    // Only the low offset bits matter once the region has been decoded.
    assign row_idx = 3'(bus.alu_result[4:2] - IO_BASE[4:2] - ROW0_OFF[4:2]);

    assign status_clr = bus.mem_write && (sel == SEL_STATUS) && bus.write_data[0];

    always_ff @(posedge clk) begin
        if (bus.mem_write && (sel == SEL_RAM))
            ram[ram_idx] <= bus.write_data;
    end

    for (genvar gi = 0; gi < NROWS; gi++) begin : g_row_we
        assign row_we[gi] = bus.mem_write && (sel == SEL_ROW) && (row_idx == 3'(gi));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_reg <= '0;
        end else begin
            for (int i = 0; i < NROWS; i++)
                if (row_we[i])
                    row_reg[i] <= bus.write_data[7:0];
        end
    end

    // A frame wrap in the same cycle as a write-1-to-clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_reg      <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            cycle_reg <= cycle_reg + 32'd1;
            if (frame_wrap)
                frame_done_reg <= 1'b1;
            else if (status_clr)
                frame_done_reg <= 1'b0;
        end
    end

    always_comb begin
        bus.read_data = '0;
        case (sel)
            SEL_RAM:    bus.read_data = ram[ram_idx];
            SEL_ROW:    bus.read_data = {24'h0, row_reg[row_idx]};
            SEL_CYCLE:  bus.read_data = cycle_reg;
            SEL_STATUS: bus.read_data = {31'h0, frame_done_reg};
            default:    bus.read_data = '0;
        endcase
    end

    led_scanner #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scanner (
        .clk        (clk),
        .reset      (reset),
        .rows       (row_reg),
        .frame_wrap (frame_wrap),
        .row_sel    (row_sel),
        .col        (col)
    );

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio: expectations are queued by the stimulus
// process and compared against the DUT on the falling edge by a monitor.
module tb_data_mem_mmio;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] row_sel;
    logic [7:0] col;

    data_mem_mmio_if bus ();

    data_mem_mmio #(
        .DEPTH    (256),
        .IO_BASE  (32'h0000_1000),
        .SCAN_DIV (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .row_sel (row_sel),
        .col     (col)
    );

    always #5 clk = ~clk;

    typedef enum {K_RD, K_ROWSEL, K_COL} kind_t;
    typedef struct {
        kind_t       kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_item;
    logic [31:0] mon_act;
    int          compared   = 0;
    int          mismatched = 0;

    task automatic expect_val(input kind_t k, input logic [31:0] e, input string n);
        exp_t t;
        t.kind = k;
        t.exp  = e;
        t.name = n;
        sb.push_back(t);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            mon_item = sb.pop_front();
            case (mon_item.kind)
                K_RD:     mon_act = bus.read_data;
                K_ROWSEL: mon_act = {24'h0, row_sel};
                default:  mon_act = {24'h0, col};
            endcase
            compared++;
            if (mon_act !== mon_item.exp) begin
                mismatched++;
                $display("FAIL %s: got %08h expected %08h", mon_item.name, mon_act, mon_item.exp);
            end else begin
                $display("ok   %s: %08h", mon_item.name, mon_act);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        bus.mem_write = 1'b0;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] e, input string n);
        bus.alu_result = addr;
        expect_val(K_RD, e, n);
        tick(1);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.mem_write  = 1'b1;
        bus.alu_result = addr;
        bus.write_data = data;
        tick(1);
        bus.mem_write  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.mem_write  = 1'b0;
        bus.alu_result = '0;
        bus.write_data = '0;
        tick(2);

        // Reset state, RAM store/load, word truncation, unmapped reads
        do_reset();
        expect_val(K_ROWSEL, 32'h01, "rst_rowsel");
        expect_val(K_COL, 32'h00, "rst_col");
        rd(32'h1020, 32'd0, "rst_cycle");
        rd(32'h1024, 32'd0, "rst_status");
        rd(32'h1000, 32'd0, "rst_row0");
        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h10, 32'hDEAD_BEEF, "t1_load");
        rd(32'h13, 32'hDEAD_BEEF, "t1_misaligned");
        rd(32'h2000, 32'd0, "t1_unmapped");
        wr(32'h0, 32'hCAFE_0000);
        wr(32'h3FC, 32'h1234_5678);
        wr(32'h400, 32'h1111_1111);
        rd(32'h0, 32'hCAFE_0000, "t1_ram_first_no_alias");
        rd(32'h3FC, 32'h1234_5678, "t1_ram_last");
        rd(32'h400, 32'd0, "t1_ram_end_unmapped");

        // Cycle counter and ignored write to it
        do_reset();
        tick(5);
        bus.alu_result = 32'h1020;
        bus.write_data = 32'h1234;
        bus.mem_write  = 1'b1;
        expect_val(K_RD, 32'd5, "t2_cycle5");
        tick(1);
        bus.mem_write  = 1'b0;
        rd(32'h1020, 32'd6, "t2_cycle6_ro");

        // Row scan with SCAN_DIV=4 and frame_done
        do_reset();
        for (int k = 0; k < 34; k++) begin
            bus.alu_result = 32'h1024;
            expect_val(K_ROWSEL, 32'd1 << ((k / 4) % 8), $sformatf("t3_rowsel_c%0d", k));
            expect_val(K_RD, (k >= 32) ? 32'd1 : 32'd0, $sformatf("t3_status_c%0d", k));
            tick(1);
        end

        // Row register writes and column output
        do_reset();
        expect_val(K_COL, 32'h00, "t4_col_before");
        wr(32'h1000, 32'hFFFF_FFA5);
        rd(32'h1000, 32'h0000_00A5, "t4_row0_read");
        expect_val(K_COL, 32'hA5, "t4_col_a5");
        wr(32'h100C, 32'h1234_563C);
        rd(32'h100C, 32'h0000_003C, "t4_row3_read");
        tick(9);
        expect_val(K_ROWSEL, 32'h08, "t4_rowsel_row3");
        expect_val(K_COL, 32'h3C, "t4_col_row3");
        wr(32'h1028, 32'hFFFF_FFFF);
        rd(32'h1028, 32'd0, "t4_unmapped_io");

        // W1C of frame_done, and set winning over a simultaneous clear
        do_reset();
        tick(32);
        rd(32'h1024, 32'd1, "t5_set");
        wr(32'h1024, 32'd1);
        rd(32'h1024, 32'd0, "t5_cleared");
        tick(28);
        bus.alu_result = 32'h1024;
        bus.write_data = 32'd1;
        bus.mem_write  = 1'b1;
        expect_val(K_RD, 32'd0, "t5_prewrap");
        tick(1);
        bus.mem_write  = 1'b0;
        expect_val(K_ROWSEL, 32'h01, "t5_wrap_rowsel");
        rd(32'h1024, 32'd1, "t5_set_wins");

        // Reset in the middle of a scan
        do_reset();
        wr(32'h1014, 32'h0000_005A);
        tick(52);
        expect_val(K_ROWSEL, 32'h20, "t6_pre_rowsel");
        expect_val(K_COL, 32'h5A, "t6_pre_col");
        rd(32'h1024, 32'd1, "t6_pre_status");
        do_reset();
        expect_val(K_ROWSEL, 32'h01, "t6_rowsel");
        expect_val(K_COL, 32'h00, "t6_col");
        rd(32'h1020, 32'd0, "t6_cycle");
        rd(32'h1024, 32'd0, "t6_status");
        rd(32'h10, 32'hDEAD_BEEF, "t6_ram_kept");
        rd(32'h1014, 32'd0, "t6_row5_cleared");

        tick(1);
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/data_mem_mmio.md
Name: data_mem_mmio

Overview:
Data-side memory responder for CPU_RISCV. It sits on the CPU's data port (mem_write, alu_result, write_data, read_data) and answers every load and store the core issues. It contains a word RAM plus a small MMIO region: an 8x8 Game-of-Life board register bank with a row-scanning LED matrix driver, a free-running cycle counter, and a frame-done status flag. Reads must be combinational because the core is single-cycle and consumes read_data in the same cycle.

Parameters:
DEPTH, 256, number of 32-bit RAM words (power of 2, ≤ 1024).
IO_BASE, 32'h0000_1000, base byte address of the MMIO region.
SCAN_DIV, 1000, clk cycles per displayed row (≥ 2).

Ports:
clk  in  1  system clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
mem_write  in  1  store strobe from the core; sampled at posedge.
alu_result  in  32  byte address from the core; bits [1:0] ignored.
write_data  in  32  store data.
read_data  out  32  load data, combinational from alu_result.
row_sel  out  8  one-hot active-high row enable for the LED matrix.
col  out  8  column data for the active row (bit i = column i lit).

Behaviour:
- Address decode (word = alu_result[31:2]):
  - RAM: alu_result < 4*DEPTH, index alu_result[log2(DEPTH)+1:2].
  - ROW[i], i=0..7: IO_BASE + 4*i. Read/write, only bits [7:0] are stored; reads zero-extend.
  - CYCLE: IO_BASE + 0x20. Read-only, 32-bit.
  - STATUS: IO_BASE + 0x24. Bit0 = frame_done; other bits read 0.
  - Anything else is unmapped.
- Reads are combinational: read_data reflects the current register/RAM contents for alu_result in the same cycle, regardless of mem_write. Unmapped reads return 0.
- Writes: on posedge when mem_write=1, the addressed RAM word or ROW[i][7:0] is updated. Writes to CYCLE and to unmapped addresses are ignored. A write to STATUS with write_data[0]=1 clears frame_done (write-1-to-clear).
- CYCLE increments by 1 every cycle and wraps from 32'hFFFF_FFFF to 0. A read returns the registered value, i.e. the pre-increment value.
- Scanner:
  - A prescaler counts 0..SCAN_DIV-1.
  - When it equals SCAN_DIV-1 it returns to 0 and the row index advances: r → r+1, and 7 → 0.
  - On the 7→0 transition frame_done is set.
  - If the set and a W1C clear occur in the same cycle, the set wins.
- Outputs: row_sel = 1 << row index; col = ROW[row index]. Both are registered, so a write to the active row appears on col the cycle after the write edge.
- Reset (synchronous): ROW[0..7]=0, CYCLE=0, prescaler=0, row index=0, frame_done=0. This gives row_sel=8'h01 and col=8'h00 in the first cycle after reset.
- RAM contents are not reset. Reset asserted mid-scan restarts the scan from row 0 at the next edge.
- read_data has no reset value of its own; it is purely combinational.
- Misaligned addresses are word-truncated and are not an error.

Decomposition:
- Shared package data_mem_pkg:
  - offset constants ROW0_OFF=0x00, CYCLE_OFF=0x20, STATUS_OFF=0x24;
  - NROWS=8;
  - an enum for the decode result {SEL_RAM, SEL_ROW, SEL_CYCLE, SEL_STATUS, SEL_NONE}.
- One natural sub-module: led_scanner. It holds the prescaler, row index, frame-wrap pulse and registered row_sel/col, taking the 8 row registers as input.
- RAM, decode and CYCLE stay in the top module.

Test Plan:
1. Reset, then store 32'hDEADBEEF to 0x10 and load 0x10 → read_data=32'hDEADBEEF. Load 0x13 → same value (word-truncated). Load 0x2000 (unmapped) → 0.
2. Reset and hold 5 cycles with no writes, then read 0x1020 → 5. Store 0x1234 to 0x1020, then read → 6 (write ignored).
3. With SCAN_DIV=4 after reset: row_sel steps 01, 02, 04, … every 4 cycles, reaching 80 at cycle 28 and back to 01 at cycle 32. STATUS reads 1 from cycle 32 onward.
4. Store 32'hFFFF_FFA5 to 0x1000 while row 0 is active → ROW[0] reads 32'h000000A5, and col=8'hA5 the next cycle.
5. With frame_done=1, store 1 to 0x1024 → STATUS reads 0. Repeat the clear in the exact cycle the row index wraps 7→0 → STATUS stays 1.
6. Assert reset during row 5 of a scan → next cycle row_sel=8'h01, col=0, CYCLE=0, STATUS=0, while RAM word 0x10 still reads 32'hDEADBEEF.
